// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: operation codes, FSM states and the
// bit positions of the {N,V,Z} flag vector.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_NOTB = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_MUL  = 3'b110,
        OP_CMP  = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int NVZ_N = 2;
    localparam int NVZ_V = 1;
    localparam int NVZ_Z = 0;

    function automatic logic [2:0] make_nvz(input logic n, input logic v, input logic z);
        logic [2:0] f;
        f        = '0;
        f[NVZ_N] = n;
        f[NVZ_V] = v;
        f[NVZ_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add unsigned multiplier: one multiplier bit per cycle for WIDTH cycles.
// 'product' is the value the accumulator takes on this edge, so it is final while 'done' is high.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;

    // Upper half accumulates the multiplicand; lower half holds the unused multiplier bits.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        product = {sum, acc[WIDTH-1:1]};
    end

    assign done = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (start) begin
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
            cnt   <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc <= product;
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with a one-deep IDLE/DONE handshake. With ALU_SEQ_MUL_EN defined,
// MUL runs on the shift-add sub-module; otherwise MUL completes at once as zero.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [2:0]       ALUop,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [2:0]       NVZ
);
    // state | meaning
    // IDLE  | in_ready=1, waiting for a request
    // BUSY  | shift-add multiply running, WIDTH cycles
    // DONE  | result registered, out_valid high this cycle

    state_e           state;
    alu_op_e          op;
    logic             accept;
    logic             go_busy;
    logic [WIDTH-1:0] res;
    logic             res_v;

    assign op       = alu_op_e'(ALUop);
    assign in_ready = (state == ST_IDLE);
    assign accept   = in_ready && in_valid;

    always_comb begin
        res   = '0;
        res_v = 1'b0;
        case (op)
            OP_ADD: begin
                res   = Ain + Bin;
                res_v = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (res[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                res   = Ain - Bin;
                res_v = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (res[WIDTH-1] != Ain[WIDTH-1]);
            end
            OP_AND:  res = Ain & Bin;
            OP_NOTB: res = ~Bin;
            OP_OR:   res = Ain | Bin;
            OP_XOR:  res = Ain ^ Bin;
            // MUL here only matters without the multiplier: zero result, flags 001.
            default: res = '0;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign go_busy = accept && (op == OP_MUL);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (go_busy),
        .a       (Ain),
        .b       (Bin),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign go_busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            out       <= '0;
            NVZ       <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (go_busy) begin
                        state <= ST_BUSY;
                    end else if (accept) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        NVZ       <= make_nvz(res[WIDTH-1], res_v, res == '0);
                        if (op != OP_CMP) begin
                            out <= res;
                        end
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                ST_BUSY: begin
                    if (mul_done) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        out       <= mul_prod[WIDTH-1:0];
                        NVZ       <= make_nvz(mul_prod[WIDTH-1], |mul_prod[2*WIDTH-1:WIDTH],
                                              mul_prod[WIDTH-1:0] == '0);
                    end
                end
`endif
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
